// File: rtl/value_buffer_freelist_pkg.sv
// Shared sizing for the immediate/PC value buffer and its free-pointer allocator.
package value_buffer_freelist_pkg;

    localparam int VB_BUFFER_NUM = 32;
    localparam int VB_BUFFER_SEL = 5;

endpackage

// File: rtl/value_buffer_freelist.sv
// Circular FIFO of free value-buffer pointers: grants up to two per cycle with zero latency,
// takes back up to two per cycle from issue; no grant under stall/prmiss, prmiss rebuilds the list.
module value_buffer_freelist
    import value_buffer_freelist_pkg::*;
#(
    parameter int BUFFER_NUM = VB_BUFFER_NUM,
    parameter int BUFFER_SEL = VB_BUFFER_SEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_1,
    input  logic                  req_2,
    input  logic                  stall,
    input  logic                  prmiss,
    input  logic                  issued_1,
    input  logic                  issued_2,
    input  logic [BUFFER_SEL-1:0] issue_ptr_1,
    input  logic [BUFFER_SEL-1:0] issue_ptr_2,
    output logic                  allocatable,
    output logic [BUFFER_SEL-1:0] ptr_1,
    output logic [BUFFER_SEL-1:0] ptr_2,
    output logic                  invalid1,
    output logic                  invalid2,
    output logic [BUFFER_SEL:0]   free_count
);

    logic [BUFFER_SEL-1:0] fifo_q [BUFFER_NUM];
    logic [BUFFER_SEL-1:0] head_q, head_d;
    logic [BUFFER_SEL-1:0] tail_q, tail_d;
    logic [BUFFER_SEL-1:0] tail_2;
    logic [BUFFER_SEL:0]   count_q, count_d;
    logic [BUFFER_NUM-1:0] free_map_q, free_map_d;
    logic [1:0]            need, pops, pushes;
    logic                  grant;

    always_comb begin
        need        = {1'b0, req_1} + {1'b0, req_2};
        allocatable = count_q >= (BUFFER_SEL+1)'(need);
        // Reset is folded in so the value buffer never sees a write during reset.
        grant       = allocatable & ~stall & ~prmiss & ~reset;
        ptr_1       = fifo_q[head_q];
        ptr_2       = fifo_q[head_q + BUFFER_SEL'(req_1)];
        invalid1    = ~(req_1 & grant);
        invalid2    = ~(req_2 & grant);
        pops        = grant ? need : 2'd0;
        pushes      = {1'b0, issued_1} + {1'b0, issued_2};
        head_d      = head_q + BUFFER_SEL'(pops);
        tail_2      = tail_q + BUFFER_SEL'(issued_1);
        tail_d      = tail_q + BUFFER_SEL'(pushes);
        count_d     = count_q - (BUFFER_SEL+1)'(pops) + (BUFFER_SEL+1)'(pushes);
        free_count  = count_q;
    end

    // Ownership shadow: one bit per entry, set while the pointer sits in the FIFO.
    always_comb begin
        free_map_d = free_map_q;
        if (grant && req_1) free_map_d[ptr_1] = 1'b0;
        if (grant && req_2) free_map_d[ptr_2] = 1'b0;
        if (issued_1)       free_map_d[issue_ptr_1] = 1'b1;
        if (issued_2)       free_map_d[issue_ptr_2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || prmiss) begin
            for (int i = 0; i < BUFFER_NUM; i++) begin
                fifo_q[i] <= BUFFER_SEL'(i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= (BUFFER_SEL+1)'(BUFFER_NUM);
            free_map_q <= '1;
        end else begin
            if (issued_1) fifo_q[tail_q] <= issue_ptr_1;
            if (issued_2) fifo_q[tail_2] <= issue_ptr_2;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            free_map_q <= free_map_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk)
        !(reset || prmiss) |-> count_d <= (BUFFER_SEL+1)'(BUFFER_NUM));
    a_distinct_free: assert property (@(posedge clk)
        !(reset || prmiss) && issued_1 && issued_2 |-> issue_ptr_1 != issue_ptr_2);
    a_free1_owned: assert property (@(posedge clk)
        !(reset || prmiss) && issued_1 |-> !free_map_q[issue_ptr_1]);
    a_free2_owned: assert property (@(posedge clk)
        !(reset || prmiss) && issued_2 |-> !free_map_q[issue_ptr_2]);

endmodule

// File: tb/tb_value_buffer_freelist.sv
// Directed and random bench for value_buffer_freelist against a queue-based free-list model.
module tb_value_buffer_freelist;

    localparam int N = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         reset, req_1, req_2, stall, prmiss, issued_1, issued_2;
    logic [S-1:0] issue_ptr_1, issue_ptr_2, ptr_1, ptr_2;
    logic         allocatable, invalid1, invalid2;
    logic [S:0]   free_count;

    always #5 clk = ~clk;

    value_buffer_freelist #(.BUFFER_NUM(N), .BUFFER_SEL(S)) dut (
        .clk(clk), .reset(reset), .req_1(req_1), .req_2(req_2), .stall(stall),
        .prmiss(prmiss), .issued_1(issued_1), .issued_2(issued_2),
        .issue_ptr_1(issue_ptr_1), .issue_ptr_2(issue_ptr_2),
        .allocatable(allocatable), .ptr_1(ptr_1), .ptr_2(ptr_2),
        .invalid1(invalid1), .invalid2(invalid2), .free_count(free_count)
    );

    int errors = 0;
    int checks = 0;
    int free_q[$];
    int alloc_q[$];
    logic [31:0] o_p1, o_p2, o_inv1, o_inv2, o_alloc, o_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reinit();
        free_q.delete();
        alloc_q.delete();
        for (int i = 0; i < N; i++) free_q.push_back(i);
    endtask

    task automatic model_release(input int p);
        for (int k = 0; k < alloc_q.size(); k++) begin
            if (alloc_q[k] == p) begin
                alloc_q.delete(k);
                break;
            end
        end
        free_q.push_back(p);
    endtask

    // One clock: drive, check combinational outputs mid-cycle, clock, check free_count.
    task automatic cycle(input bit r1, input bit r2, input bit st, input bit pm,
                         input bit i1, input int p1, input bit i2, input int p2);
        int  need;
        bit  ok, g;
        req_1 = r1; req_2 = r2; stall = st; prmiss = pm;
        issued_1 = i1; issue_ptr_1 = S'(p1);
        issued_2 = i2; issue_ptr_2 = S'(p2);
        #2;
        need = int'(r1) + int'(r2);
        ok   = free_q.size() >= need;
        g    = ok && !st && !pm;
        o_p1 = 32'(ptr_1); o_p2 = 32'(ptr_2);
        o_inv1 = 32'(invalid1); o_inv2 = 32'(invalid2); o_alloc = 32'(allocatable);
        chk("allocatable", o_alloc, 32'(ok));
        chk("invalid1", o_inv1, 32'(!(r1 && g)));
        chk("invalid2", o_inv2, 32'(!(r2 && g)));
        if (g && r1) chk("ptr_1", o_p1, free_q[0]);
        if (g && r2) chk("ptr_2", o_p2, free_q[r1 ? 1 : 0]);
        @(posedge clk);
        #1;
        if (pm) begin
            model_reinit();
        end else begin
            if (g) repeat (need) alloc_q.push_back(free_q.pop_front());
            if (i1) model_release(p1);
            if (i2) model_release(p2);
        end
        o_fc = 32'(free_count);
        chk("free_count", o_fc, free_q.size());
    endtask

    initial begin
        int a, b;
        reset = 1'b1; req_1 = 1'b1; req_2 = 1'b1; stall = 1'b0; prmiss = 1'b0;
        issued_1 = 1'b0; issued_2 = 1'b0; issue_ptr_1 = '0; issue_ptr_2 = '0;
        model_reinit();

        // Reset state
        @(posedge clk); #1; @(posedge clk); #1;
        chk("rst_free_count", 32'(free_count), N);
        chk("rst_allocatable", 32'(allocatable), 1);
        chk("rst_ptr_1", 32'(ptr_1), 0);
        chk("rst_ptr_2_req1", 32'(ptr_2), 1);
        chk("rst_invalid1", 32'(invalid1), 1);
        chk("rst_invalid2", 32'(invalid2), 1);
        req_1 = 1'b0; #1;
        chk("rst_ptr_2_noreq1", 32'(ptr_2), 0);
        reset = 1'b0;

        // Drain with dual grants
        for (int k = 0; k < 16; k++) begin
            cycle(1, 1, 0, 0, 0, 0, 0, 0);
            chk("dual_p1", o_p1, 2 * k);
            chk("dual_p2", o_p2, 2 * k + 1);
        end
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        chk("empty_alloc", o_alloc, 0);
        chk("empty_fc", o_fc, 0);

        // Free into an empty FIFO, granted next cycle
        cycle(1, 0, 0, 0, 1, 7, 0, 0);
        chk("refill_inv1_now", o_inv1, 1);
        chk("refill_fc", o_fc, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("refill_ptr1", o_p1, 7);
        chk("refill_inv1_next", o_inv1, 0);
        chk("refill_fc_after", o_fc, 0);

        // Single free entry against a dual request
        cycle(0, 0, 0, 0, 1, 12, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        chk("partial_alloc", o_alloc, 0);
        chk("partial_inv1", o_inv1, 1);
        chk("partial_inv2", o_inv2, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("partial_ptr1", o_p1, 12);
        chk("partial_inv1_ok", o_inv1, 0);

        // Lone req_2 takes the head entry
        cycle(0, 0, 0, 0, 1, 5, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        chk("lone2_ptr2", o_p2, 5);
        chk("lone2_inv1", o_inv1, 1);
        chk("lone2_inv2", o_inv2, 0);

        // Walk head and tail to 31, then straddle the wrap
        for (int k = 0; k < 14; k++) begin
            a = alloc_q[0]; b = alloc_q[1];
            cycle(0, 0, 0, 0, 1, a, 1, b);
        end
        for (int k = 0; k < 14; k++) cycle(1, 1, 0, 0, 0, 0, 0, 0);
        a = alloc_q[3]; b = alloc_q[20];
        cycle(0, 0, 0, 0, 1, a, 1, b);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap_p1", o_p1, a);
        chk("wrap_p2", o_p2, b);

        // Misprediction overrides requests and frees
        a = alloc_q[0];
        cycle(1, 1, 0, 1, 1, a, 0, 0);
        chk("prmiss_inv1", o_inv1, 1);
        chk("prmiss_inv2", o_inv2, 1);
        chk("prmiss_fc", o_fc, N);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        chk("prmiss_ptr1", o_p1, 0);

        // Stall blocks grants but not frees
        cycle(1, 1, 1, 0, 1, 0, 0, 0);
        chk("stall_inv1", o_inv1, 1);
        chk("stall_inv2", o_inv2, 1);
        chk("stall_fc", o_fc, N - 1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit r1, r2, st, pm, i1, i2;
            int p1, p2, x1, x2;
            r1 = 1'($urandom % 2);
            r2 = 1'($urandom % 2);
            st = ($urandom % 8) == 0;
            pm = ($urandom % 60) == 0;
            i1 = 0; i2 = 0; p1 = 0; p2 = 0;
            if (alloc_q.size() > 0 && ($urandom % 3) != 0) begin
                i1 = 1;
                x1 = $urandom_range(0, alloc_q.size() - 1);
                p1 = alloc_q[x1];
                if (alloc_q.size() > 1 && ($urandom % 2) == 0) begin
                    x2 = $urandom_range(0, alloc_q.size() - 2);
                    if (x2 >= x1) x2++;
                    i2 = 1;
                    p2 = alloc_q[x2];
                end
            end
            cycle(r1, r2, st, pm, i1, p1, i2, p2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
